// File: rtl/operand_pkg.sv
// operand_pkg: shared constants for the operand-read stage and its regfile.
// Holds data/regfile sizes, control-bundle width and field offsets, rs indices.
package operand_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int RA_W  = 5;

    // ctl bundle {rd_type, exe_unit, func_code, func3, func2, endsim, auipc}
    localparam int CTL_W        = 19;
    localparam int CTL_AUIPC    = 0;
    localparam int CTL_ENDSIM   = 1;
    localparam int CTL_FUNC2    = 2;
    localparam int CTL_FUNC3    = 4;
    localparam int CTL_FUNCCODE = 7;
    localparam int CTL_EXEUNIT  = 14;
    localparam int CTL_RDTYPE   = 17;

    localparam int RS1 = 0;
    localparam int RS2 = 1;
    localparam int RS3 = 2;

endpackage

// File: rtl/operand_regfile.sv
// operand_regfile: NREGS x XLEN integer regfile, NRD comb read ports with
// writeback bypass, WB_W write ports (highest port wins); x0 is hardwired 0.
module operand_regfile
    import operand_pkg::*;
#(
    parameter int NRD   = 4,
    parameter int WB_W  = 2,
    parameter int XLEN  = operand_pkg::XLEN,
    parameter int NREGS = operand_pkg::NREGS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*RA_W-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic [WB_W-1:0]      wb_valid,
    input  logic [WB_W*RA_W-1:0] wb_rd,
    input  logic [WB_W*XLEN-1:0] wb_value
);

    logic [XLEN-1:0] mem [NREGS];

    function automatic logic live(input logic [RA_W-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    // Later ports are written last, so the highest index wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int p = 0; p < WB_W; p++) begin
                if (wb_valid[p] && live(wb_rd[p*RA_W +: RA_W]))
                    mem[wb_rd[p*RA_W +: RA_W]] <= wb_value[p*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (live(rd_addr[k*RA_W +: RA_W])) begin
                rd_data[k*XLEN +: XLEN] = mem[rd_addr[k*RA_W +: RA_W]];
                for (int p = 0; p < WB_W; p++) begin
                    if (wb_valid[p] &&
                        wb_rd[p*RA_W +: RA_W] == rd_addr[k*RA_W +: RA_W])
                        rd_data[k*XLEN +: XLEN] = wb_value[p*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/operand_read_stage.sv
// operand_read_stage: registers ISSUE_W decoded lanes and their bypassed
// operands; stall holds fields but refreshes operand values, flush kills
// valid. Ports: clk, rst, stall_i, flush_i, in_* lane bundle, out_* lane
// bundle + out_rs_value_o, wb_* writeback ports. Option: OPERAND_RS3_EN.
module operand_read_stage
    import operand_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int WB_W    = 2,
    parameter int XLEN    = operand_pkg::XLEN,
    parameter int NREGS   = operand_pkg::NREGS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_i,
    input  logic                        flush_i,
    input  logic [ISSUE_W-1:0]          in_valid_i,
    input  logic [ISSUE_W*64-1:0]       in_pc_i,
    input  logic [ISSUE_W*32-1:0]       in_inst_i,
    input  logic [ISSUE_W*3-1:0]        in_rs_valid_i,
    input  logic [ISSUE_W*15-1:0]       in_rs_i,
    input  logic [ISSUE_W*5-1:0]        in_rd_i,
    input  logic [ISSUE_W*CTL_W-1:0]    in_ctl_i,
    output logic [ISSUE_W-1:0]          out_valid_o,
    output logic [ISSUE_W*64-1:0]       out_pc_o,
    output logic [ISSUE_W*32-1:0]       out_inst_o,
    output logic [ISSUE_W*3-1:0]        out_rs_valid_o,
    output logic [ISSUE_W*15-1:0]       out_rs_o,
    output logic [ISSUE_W*5-1:0]        out_rd_o,
    output logic [ISSUE_W*CTL_W-1:0]    out_ctl_o,
    output logic [ISSUE_W*3*XLEN-1:0]   out_rs_value_o,
    input  logic [WB_W-1:0]             wb_valid_i,
    input  logic [WB_W*5-1:0]           wb_rd_i,
    input  logic [WB_W*XLEN-1:0]        wb_value_i
);

`ifdef OPERAND_RS3_EN
    localparam int NRS = 3;
`else
    localparam int NRS = 2;
`endif
    localparam int NRD = ISSUE_W * NRS;
    localparam logic [2:0] RS_MASK = (NRS == 3) ? 3'b111 : 3'b111 ^ (3'b1 << RS3);

    logic [NRD*RA_W-1:0]         rd_addr;
    logic [NRD*XLEN-1:0]         rd_data;
    logic [ISSUE_W*3*XLEN-1:0]   nxt_value;
    logic [ISSUE_W*3-1:0]        nxt_rs_valid;

    assign nxt_rs_valid = in_rs_valid_i & {ISSUE_W{RS_MASK}};

    // While stalled the read ports follow the held addresses so a
    // writeback landing during the stall refreshes the held operand.
    always_comb begin
        rd_addr   = '0;
        nxt_value = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int j = 0; j < NRS; j++) begin
                rd_addr[(i*NRS+j)*RA_W +: RA_W] = stall_i
                    ? out_rs_o[(i*3+j)*5 +: 5]
                    : in_rs_i[(i*3+j)*5 +: 5];
                if (stall_i ? out_rs_valid_o[i*3+j] : nxt_rs_valid[i*3+j])
                    nxt_value[(i*3+j)*XLEN +: XLEN] =
                        rd_data[(i*NRS+j)*XLEN +: XLEN];
            end
        end
    end

    operand_regfile #(
        .NRD   (NRD),
        .WB_W  (WB_W),
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wb_valid (wb_valid_i),
        .wb_rd    (wb_rd_i),
        .wb_value (wb_value_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o    <= '0;
            out_pc_o       <= '0;
            out_inst_o     <= '0;
            out_rs_valid_o <= '0;
            out_rs_o       <= '0;
            out_rd_o       <= '0;
            out_ctl_o      <= '0;
            out_rs_value_o <= '0;
        end else if (flush_i) begin
            out_valid_o    <= '0;
        end else if (stall_i) begin
            out_rs_value_o <= nxt_value;
        end else begin
            out_valid_o    <= in_valid_i;
            out_pc_o       <= in_pc_i;
            out_inst_o     <= in_inst_i;
            out_rs_valid_o <= nxt_rs_valid;
            out_rs_o       <= in_rs_i;
            out_rd_o       <= in_rd_i;
            out_ctl_o      <= in_ctl_i;
            out_rs_value_o <= nxt_value;
        end
    end

endmodule

// File: tb/tb_operand_read_stage.sv
// tb_operand_read_stage: scoreboard bench for operand_read_stage.
// Expectations come from a shadow regfile and a shadow pipeline register.
module tb_operand_read_stage;
    import operand_pkg::*;

`ifdef OPERAND_RS3_EN
    localparam bit RS3_ON = 1'b1;
`else
    localparam bit RS3_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              stall, flush;
    logic [1:0]        in_valid;
    logic [127:0]      in_pc;
    logic [63:0]       in_inst;
    logic [5:0]        in_rs_valid;
    logic [29:0]       in_rs;
    logic [9:0]        in_rd;
    logic [2*CTL_W-1:0] in_ctl;
    logic [1:0]        out_valid;
    logic [127:0]      out_pc;
    logic [63:0]       out_inst;
    logic [5:0]        out_rs_valid;
    logic [29:0]       out_rs;
    logic [9:0]        out_rd;
    logic [2*CTL_W-1:0] out_ctl;
    logic [383:0]      out_rs_value;
    logic [1:0]        wb_valid;
    logic [9:0]        wb_rd;
    logic [127:0]      wb_value;

    operand_read_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_pc_i        (in_pc),
        .in_inst_i      (in_inst),
        .in_rs_valid_i  (in_rs_valid),
        .in_rs_i        (in_rs),
        .in_rd_i        (in_rd),
        .in_ctl_i       (in_ctl),
        .out_valid_o    (out_valid),
        .out_pc_o       (out_pc),
        .out_inst_o     (out_inst),
        .out_rs_valid_o (out_rs_valid),
        .out_rs_o       (out_rs),
        .out_rd_o       (out_rd),
        .out_ctl_o      (out_ctl),
        .out_rs_value_o (out_rs_value),
        .wb_valid_i     (wb_valid),
        .wb_rd_i        (wb_rd),
        .wb_value_i     (wb_value)
    );

    typedef struct {
        string       name;
        int          kind;
        int          lane;
        int          rs;
        logic [63:0] val;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] model [32];
    logic [1:0]  h_valid;
    logic [63:0] h_pc [2];
    logic [2:0]  h_rsv [2];
    logic [14:0] h_rs [2];

    function automatic logic [63:0] got(input int kind, input int lane, input int rs);
        case (kind)
            0:       return out_rs_value[(lane*3+rs)*64 +: 64];
            1:       return 64'(out_valid);
            2:       return out_pc[lane*64 +: 64];
            default: return 64'(out_rs_valid[lane*3+rs]);
        endcase
    endfunction

    function automatic logic [63:0] bypass(input logic [4:0] a);
        logic [63:0] v;
        if (a == 5'd0) return 64'd0;
        v = model[a];
        for (int p = 0; p < 2; p++)
            if (wb_valid[p] && wb_rd[p*5 +: 5] == a) v = wb_value[p*64 +: 64];
        return v;
    endfunction

    task automatic clear_inputs();
        stall = 0; flush = 0;
        in_valid = '0; in_pc = '0; in_inst = '0; in_rs_valid = '0;
        in_rs = '0; in_rd = '0; in_ctl = '0;
        wb_valid = '0; wb_rd = '0; wb_value = '0;
    endtask

    task automatic reset_model();
        for (int r = 0; r < 32; r++) model[r] = 64'd0;
        h_valid = '0;
        for (int i = 0; i < 2; i++) begin
            h_pc[i] = '0; h_rsv[i] = '0; h_rs[i] = '0;
        end
    endtask

    task automatic set_lane(input int i, input logic v, input logic [63:0] pc,
                            input logic [2:0] rsv, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [4:0] r3);
        in_valid[i]             = v;
        in_pc[i*64 +: 64]       = pc;
        in_inst[i*32 +: 32]     = pc[31:0] ^ 32'h13;
        in_rs_valid[i*3 +: 3]   = rsv;
        in_rs[i*15 +: 15]       = {r3, r2, r1};
        in_rd[i*5 +: 5]         = r1 ^ 5'h1;
        in_ctl[i*CTL_W +: CTL_W] = pc[CTL_W-1:0];
    endtask

    task automatic set_wb(input int p, input logic [4:0] rd, input logic [63:0] v);
        wb_valid[p]          = 1'b1;
        wb_rd[p*5 +: 5]      = rd;
        wb_value[p*64 +: 64] = v;
    endtask

    // Push the expectations for the current inputs, clock once, update
    // the shadow regfile, and return at the following falling edge.
    task automatic step(input string tag);
        exp_t        e;
        logic        v;
        logic [4:0]  a;
        e.name = tag;
        e.kind = 1; e.lane = 0; e.rs = 0;
        e.val = flush ? 64'd0 : (stall ? 64'(h_valid) : 64'(in_valid));
        q.push_back(e);
        if (!flush) begin
            for (int i = 0; i < 2; i++) begin
                e.lane = i; e.rs = 0; e.kind = 2;
                e.val = stall ? h_pc[i] : in_pc[i*64 +: 64];
                q.push_back(e);
                for (int j = 0; j < 3; j++) begin
                    v = stall ? h_rsv[i][j] : in_rs_valid[i*3+j];
                    a = stall ? h_rs[i][j*5 +: 5] : in_rs[i*15+j*5 +: 5];
                    if (j == 2 && !RS3_ON) v = 1'b0;
                    e.rs = j;
                    e.kind = 0; e.val = v ? bypass(a) : 64'd0; q.push_back(e);
                    e.kind = 3; e.val = 64'(v); q.push_back(e);
                end
            end
        end
        if (flush) h_valid = '0;
        else if (!stall) begin
            h_valid = in_valid;
            for (int i = 0; i < 2; i++) begin
                h_pc[i]  = in_pc[i*64 +: 64];
                h_rsv[i] = in_rs_valid[i*3 +: 3];
                h_rs[i]  = in_rs[i*15 +: 15];
            end
        end
        @(posedge clk);
        for (int p = 0; p < 2; p++)
            if (wb_valid[p] && wb_rd[p*5 +: 5] != 5'd0)
                model[wb_rd[p*5 +: 5]] = wb_value[p*64 +: 64];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        reset_model();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 2'b00) begin
            errors++; $display("FAIL reset_valid: got %b want 00", out_valid);
        end
        checks++;
        if (out_pc !== '0) begin
            errors++; $display("FAIL reset_pc: got %h want 0", out_pc);
        end
        checks++;
        if (out_rs_value !== '0) begin
            errors++; $display("FAIL reset_value: got %h want 0", out_rs_value);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            clear_inputs();
            if (c == 0) set_wb(0, 5'd5, 64'hA5);
            else set_lane(0, 1'b1, 64'h1000, 3'b001, 5'd5, 5'd0, 5'd0);
            step("write_read");
            while (q.size() != 0) begin
                e = q.pop_front(); checks++;
                if (got(e.kind, e.lane, e.rs) !== e.val) begin
                    errors++;
                    $display("FAIL %s k%0d l%0d r%0d: got %h want %h", e.name,
                             e.kind, e.lane, e.rs, got(e.kind, e.lane, e.rs), e.val);
                end
            end
        end
        checks++;
        if (out_rs_value[63:0] !== 64'hA5) begin
            errors++; $display("FAIL wr_x5: got %h want a5", out_rs_value[63:0]);
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            clear_inputs();
            set_lane(1, 1'b1, 64'h2000 + 64'(c), 3'b010, 5'd0, 5'd7, 5'd0);
            if (c == 0) set_wb(1, 5'd7, 64'h1234);
            step("bypass");
            while (q.size() != 0) begin
                e = q.pop_front(); checks++;
                if (got(e.kind, e.lane, e.rs) !== e.val) begin
                    errors++;
                    $display("FAIL %s k%0d l%0d r%0d: got %h want %h", e.name,
                             e.kind, e.lane, e.rs, got(e.kind, e.lane, e.rs), e.val);
                end
            end
            checks++;
            if (out_rs_value[(3+1)*64 +: 64] !== 64'h1234) begin
                errors++;
                $display("FAIL bypass_x7: got %h want 1234", out_rs_value[(3+1)*64 +: 64]);
            end
        end
    endtask

    task automatic test_stall_refresh();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    set_lane(0, 1'b1, 64'h100, 3'b001, 5'd3, 5'd0, 5'd0);
                    set_lane(1, 1'b1, 64'h200, 3'b010, 5'd0, 5'd4, 5'd0);
                end
                1: begin
                    stall = 1'b1;
                    set_wb(0, 5'd3, 64'hBEEF);
                    set_lane(0, 1'b1, 64'h999, 3'b001, 5'd8, 5'd0, 5'd0);
                end
                2: stall = 1'b1;
                default: set_lane(0, 1'b1, 64'h300, 3'b011, 5'd3, 5'd5, 5'd0);
            endcase
            step("stall");
            while (q.size() != 0) begin
                e = q.pop_front(); checks++;
                if (got(e.kind, e.lane, e.rs) !== e.val) begin
                    errors++;
                    $display("FAIL %s k%0d l%0d r%0d: got %h want %h", e.name,
                             e.kind, e.lane, e.rs, got(e.kind, e.lane, e.rs), e.val);
                end
            end
            if (c == 1) begin
                checks++;
                if (out_rs_value[63:0] !== 64'hBEEF || out_pc[63:0] !== 64'h100) begin
                    errors++;
                    $display("FAIL stall_refresh: got %h pc %h want beef pc 100",
                             out_rs_value[63:0], out_pc[63:0]);
                end
            end
        end
    endtask

    task automatic test_collision_x0();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    set_wb(0, 5'd9, 64'h1);
                    set_wb(1, 5'd9, 64'h2);
                    set_lane(0, 1'b1, 64'h400, 3'b001, 5'd9, 5'd0, 5'd0);
                end
                1: set_lane(0, 1'b1, 64'h404, 3'b011, 5'd9, 5'd9, 5'd0);
                2: begin
                    set_wb(0, 5'd0, 64'hFF);
                    set_lane(0, 1'b1, 64'h408, 3'b001, 5'd0, 5'd0, 5'd0);
                end
                default: set_lane(1, 1'b1, 64'h40C, 3'b011, 5'd0, 5'd0, 5'd0);
            endcase
            step("collide_x0");
            while (q.size() != 0) begin
                e = q.pop_front(); checks++;
                if (got(e.kind, e.lane, e.rs) !== e.val) begin
                    errors++;
                    $display("FAIL %s k%0d l%0d r%0d: got %h want %h", e.name,
                             e.kind, e.lane, e.rs, got(e.kind, e.lane, e.rs), e.val);
                end
            end
            if (c == 1) begin
                checks++;
                if (out_rs_value[63:0] !== 64'h2) begin
                    errors++; $display("FAIL collide_x9: got %h want 2", out_rs_value[63:0]);
                end
            end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            set_lane(0, 1'b1, 64'h500 + 64'(c), 3'b001, 5'd5, 5'd0, 5'd0);
            set_lane(1, 1'b1, 64'h600 + 64'(c), 3'b010, 5'd0, 5'd9, 5'd0);
            if (c == 1) begin
                stall = 1'b1; flush = 1'b1;
            end
            step("flush");
            while (q.size() != 0) begin
                e = q.pop_front(); checks++;
                if (got(e.kind, e.lane, e.rs) !== e.val) begin
                    errors++;
                    $display("FAIL %s k%0d l%0d r%0d: got %h want %h", e.name,
                             e.kind, e.lane, e.rs, got(e.kind, e.lane, e.rs), e.val);
                end
            end
        end
        checks++;
        if (out_pc[127:64] !== 64'h602) begin
            errors++; $display("FAIL flush_recapture: got %h want 602", out_pc[127:64]);
        end
    endtask

    task automatic test_rs3();
        exp_t e;
        clear_inputs();
        set_lane(0, 1'b1, 64'h700, 3'b100, 5'd0, 5'd0, 5'd5);
        step("rs3");
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (got(e.kind, e.lane, e.rs) !== e.val) begin
                errors++;
                $display("FAIL %s k%0d l%0d r%0d: got %h want %h", e.name,
                         e.kind, e.lane, e.rs, got(e.kind, e.lane, e.rs), e.val);
            end
        end
        checks++;
        if (out_rs_value[2*64 +: 64] !== (RS3_ON ? 64'hA5 : 64'd0)) begin
            errors++; $display("FAIL rs3_value: got %h", out_rs_value[2*64 +: 64]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c < 24; c++) begin
            clear_inputs();
            stall = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 1) == 1)
                    set_wb(p, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            for (int i = 0; i < 2; i++)
                set_lane(i, 1'($urandom_range(0, 1)), 64'($urandom),
                         3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step("b2b");
            while (q.size() != 0) begin
                e = q.pop_front(); checks++;
                if (got(e.kind, e.lane, e.rs) !== e.val) begin
                    errors++;
                    $display("FAIL %s c%0d k%0d l%0d r%0d: got %h want %h", e.name, c,
                             e.kind, e.lane, e.rs, got(e.kind, e.lane, e.rs), e.val);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        clear_inputs();
        set_lane(0, 1'b1, 64'h800, 3'b001, 5'd5, 5'd0, 5'd0);
        set_lane(1, 1'b1, 64'h900, 3'b001, 5'd5, 5'd0, 5'd0);
        step("pre_rst");
        stall = 1'b1;
        step("pre_rst_stall");
        q.delete();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 2'b00 || out_rs_value !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid %b value %h want 0",
                     out_valid, out_rs_value[63:0]);
        end
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        step("post_rst");
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (got(e.kind, e.lane, e.rs) !== e.val) begin
                errors++;
                $display("FAIL %s k%0d l%0d r%0d: got %h want %h", e.name,
                         e.kind, e.lane, e.rs, got(e.kind, e.lane, e.rs), e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_stall_refresh();
        test_collision_x0();
        test_flush();
        test_rs3();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_read_stage.md
# operand_read_stage

Parametrised operand-read pipeline stage between the decoder and the scoreboard/issue logic. It registers up to ISSUE_W decoded instructions per cycle and reads their source registers from an internal multi-ported integer register file. Writeback values are bypassed into the read path in the same cycle. While the stage is stalled, held operand values are refreshed so that a writeback landing during the stall is never lost.

## Interface
Parameters:
- ISSUE_W, 2, number of instruction lanes
- WB_W, 2, number of writeback ports
- XLEN, 64, register and data width
- NREGS, 32, architectural registers; register 0 reads as zero

Ports (lane/port vectors are packed, lane i at slice i):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  hold the output registers (from scoreboard)
- flush_i  in  1  kill all lanes (from wb)
- in_valid_i  in  ISSUE_W  per-lane decoder valid
- in_pc_i  in  ISSUE_W*64  per-lane pc
- in_inst_i  in  ISSUE_W*32  per-lane raw instruction
- in_rs_valid_i  in  ISSUE_W*3  per-lane rs1/rs2/rs3 valid
- in_rs_i  in  ISSUE_W*15  per-lane rs1/rs2/rs3 addresses, 5 bits each
- in_rd_i  in  ISSUE_W*5  per-lane destination
- in_ctl_i  in  ISSUE_W*CTL_W  per-lane control bundle {rd_type, exe_unit, func_code, func3, func2, endsim, auipc}, CTL_W=19
- out_valid_o  out  ISSUE_W  registered lane valid
- out_pc_o, out_inst_o, out_rs_valid_o, out_rs_o, out_rd_o, out_ctl_o  out  same widths as inputs  registered copies
- out_rs_value_o  out  ISSUE_W*3*XLEN  operand values
- wb_valid_i  in  WB_W  writeback enables
- wb_rd_i  in  WB_W*5  writeback destinations
- wb_value_i  in  WB_W*XLEN  writeback data

## Operation
- Regfile: NREGS x XLEN, 3*ISSUE_W combinational read ports, WB_W write ports.
- Writes to x0 are ignored. Reads of x0 return 0.
- Write collision (two ports, same rd, same cycle): highest-index port wins.
- Read bypass: if any valid wb port targets a non-zero address being read, that wb value is used (highest index wins). Otherwise the stored value is used.
- rs value with rs_valid=0: 0.
- Capture (stall_i=0, flush_i=0): all out_* fields load from inputs. Values load from the bypassed read of the in_rs addresses.
- Hold (stall_i=1, flush_i=0): valid, pc, inst, rs, rd and ctl hold. Each out_rs_value is re-read from the bypassed regfile using the held out_rs addresses.
- Flush: out_valid cleared on the next edge. Flush takes priority over stall. Data fields may keep their values; they are don't-care when valid=0.
- Lanes are independent. An invalid lane still captures fields; only valid is meaningful.

## Timing
- Latency 1 cycle: input at edge N appears on outputs after edge N.
- WB on cycle N is visible to an in-stage read on the same cycle N (bypass). It is also stored at edge N.
- Reset: out_valid=0, all other outputs 0, all registers 0. Reset is asynchronous; if asserted mid-stall, the stage comes up empty.
- stall_i and flush_i are sampled at the edge only, with no combinational path to the outputs.

## Configuration
- OPERAND_RS3_EN defined: rs3 read ports exist for every lane, giving 3*ISSUE_W read ports.
- OPERAND_RS3_EN undefined: rs3 read ports are not built. The out_rs3 value and valid are tied 0. in_rs3 inputs are ignored, and the port list is unchanged.

## Structure
- operand_pkg holds XLEN, NREGS, CTL_W, the ctl bundle field offsets and the rs index constants RS1=0, RS2=1, RS3=2.
- One sub-module, operand_regfile: multi-port storage, write-priority and bypass mux. Parametrised by read-port count, WB_W, XLEN and NREGS.
- The top level holds the pipeline register and the stall/flush control.

## Test plan
- Reset release, then write x5=0xA5 via wb0, then lane0 reads rs1=x5 one cycle later -> out_rs_value lane0 rs1=0xA5, out_valid=01.
- Same-cycle bypass: wb1 writes x7=0x1234 while lane1 rs2=x7 is captured -> next cycle value 0x1234.
- Stall refresh: lane0 held with rs1=x3 (old 0), wb0 writes x3=0xBEEF during the stall -> out value becomes 0xBEEF the next cycle, while valid/pc are unchanged.
- Collision and x0: wb0 and wb1 both write x9 (0x1, 0x2) -> read returns 0x2. A write of x0=0xFF -> read of x0 returns 0.
- Flush and stall together with out_valid=11 -> out_valid=00 next cycle. After deasserting both, new inputs are captured.
- Without OPERAND_RS3_EN: rs3_valid=1 with rs3=x5 (x5 nonzero) -> rs3 value 0 and rs3 valid 0.
